// File: rtl/dram_test_pkg.sv
// dram_test_pkg: shared FSM states and UART constants for the distributed-RAM dump path
package dram_test_pkg;
  typedef enum logic [2:0] {IDLE, HDR, READ, SEND, CHK, DONE} state_t;
  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int UART_BITS = 10;
endpackage

// File: rtl/uart_tx_8n1.sv
// uart_tx_8n1: 8N1 serialiser with valid/ready byte hand-off
// ports: clk, rst, data[7:0]/valid in, ready out, tx line out (idle high)
module uart_tx_8n1
  import dram_test_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] cnt;
  logic [3:0] bitn;
  logic [9:0] sh;
  logic active, last;
  assign last = (bitn == 4'(UART_BITS - 1)) && (cnt == CW'(CLKS_PER_BIT - 1));
  // the final stop-bit cycle also counts as idle so the next start bit follows with no gap
  assign ready = !active || last;
  assign tx = active ? sh[0] : 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      cnt <= '0;
      bitn <= '0;
      sh <= '1;
    end else if (valid && ready) begin
      active <= 1'b1;
      cnt <= '0;
      bitn <= '0;
      sh <= {1'b1, data, 1'b0};
    end else if (active) begin
      if (cnt == CW'(CLKS_PER_BIT - 1)) begin
        cnt <= '0;
        bitn <= bitn + 4'd1;
        sh <= {1'b1, sh[9:1]};
        active <= !last;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/dram_uart_dumper.sv
// dram_uart_dumper: streams every RAM word out of tx as header, LSB-first word bytes, XOR checksum
// ports: clk, rst, start in; ram_addr out / ram_rdata in (async read port); tx, busy, done out
module dram_uart_dumper
  import dram_test_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         ADDR_W       = 5,
  parameter int         DATA_W       = 16,
  parameter logic [7:0] HEADER       = HEADER_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  localparam int NB = DATA_W / 8;
  localparam int KW = NB > 1 ? $clog2(NB) : 1;
  state_t state;
  logic [DATA_W-1:0] wbuf;
  logic [KW-1:0] k;
  logic [7:0] chk;
  logic chk_sent;
  logic u_valid, u_ready;
  logic [7:0] u_data;
  always_comb begin
    u_valid = state == HDR || state == SEND || (state == CHK && !chk_sent);
    u_data = state == HDR ? HEADER : state == CHK ? chk : wbuf[7:0];
  end
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ram_addr <= '0;
      wbuf <= '0;
      k <= '0;
      chk <= '0;
      chk_sent <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= HDR;
          ram_addr <= '0;
          chk <= '0;
          chk_sent <= 1'b0;
        end
        HDR: if (u_ready) state <= READ;
        READ: begin
          wbuf <= ram_rdata;
          ram_addr <= ram_addr + ADDR_W'(1);
          k <= '0;
          state <= SEND;
        end
        // ram_addr was bumped in READ, so it reads 0 only after the last word wrapped
        SEND: if (u_ready) begin
          chk <= chk ^ wbuf[7:0];
          wbuf <= wbuf >> 8;
          k <= k + KW'(1);
          if (k == KW'(NB - 1)) state <= ram_addr == '0 ? CHK : READ;
        end
        // first ready loads the checksum byte, the second marks the end of its stop bit
        CHK: if (u_ready) begin
          chk_sent <= 1'b1;
          if (chk_sent) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  uart_tx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(clk),
    .rst(rst),
    .data(u_data),
    .valid(u_valid),
    .ready(u_ready),
    .tx(tx)
  );
endmodule

// File: tb/tb_dram_uart_dumper.sv
// tb_dram_uart_dumper: directed checks of the RAM dump frame, UART bit timing, start filtering and reset
module tb_dram_uart_dumper;
  localparam int CPB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [4:0] ram_addr;
  logic [15:0] ram_rdata;
  logic tx, busy, done;
  logic [15:0] mem [32];
  logic [8:0] rxq [$];
  logic [7:0] mon_b;
  int total = 0;
  int passed = 0;
  int done_cnt = 0;

  assign ram_rdata = mem[ram_addr];

  dram_uart_dumper #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .ram_addr(ram_addr),
    .ram_rdata(ram_rdata),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  // UART monitor: mid-bit sampling, offset 18 ns keeps samples off clock edges; stores {stop, data}
  initial forever begin
    @(negedge tx);
    #18;
    for (int i = 0; i < 8; i++) begin
      #40;
      mon_b[i] = tx;
    end
    #40;
    rxq.push_back({tx, mon_b});
  end

  function automatic logic [15:0] pat(input int a);
    logic [4:0] x;
    x = a[4:0];
    return {~x, 3'b0, x, 3'b0};
  endfunction

  task automatic run_start(input int repulse_n, input bit pulse_done, output int n);
    done_cnt = 0;
    n = 0;
    start = 1'b1;
    while (n < 4000) begin
      @(negedge clk);
      n++;
      start = (n == repulse_n);
      if (done) break;
    end
    if (pulse_done) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (tx !== 1'b1) $display("FAIL reset_tx got %b want 1", tx); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (ram_addr !== 5'd0) $display("FAIL reset_addr got %0d want 0", ram_addr); else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_ram;
    int n, bad;
    foreach (mem[i]) mem[i] = 16'h0;
    rxq.delete();
    run_start(0, 1'b0, n);
    // start sampled at edge 0, tx spans edges 1..2641, DONE entered at edge 2641
    total++; if (n !== 2642) $display("FAIL zero_latency got %0d want 2642", n); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL zero_busy_at_done got %b want 0", busy); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL zero_done_width got %b want 0", done); else passed++;
    total++; if (done_cnt !== 1) $display("FAIL zero_done_count got %0d want 1", done_cnt); else passed++;
    total++; if (rxq.size() !== 66) $display("FAIL zero_len got %0d want 66", rxq.size()); else passed++;
    total++; if (rxq[0] !== 9'h1A5) $display("FAIL zero_header got %h want 1a5", rxq[0]); else passed++;
    bad = 0;
    for (int i = 1; i < 65; i++) if (rxq[i] !== 9'h100) bad++;
    total++; if (bad !== 0) $display("FAIL zero_data got %0d bad bytes want 0", bad); else passed++;
    total++; if (rxq[65] !== 9'h100) $display("FAIL zero_chk got %h want 100", rxq[65]); else passed++;
  endtask

  task automatic test_bit_timing;
    logic [9:0] p;
    logic [9:0] bad;
    int n;
    p = {1'b1, 8'hA5, 1'b0};
    bad = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (tx !== 1'b1) $display("FAIL timing_pre got %b want 1", tx); else passed++;
    for (int c = 2; c < 42; c++) begin
      @(negedge clk);
      if (tx !== p[(c - 2) / 4]) bad[(c - 2) / 4] = 1'b1;
    end
    for (int b = 0; b < 10; b++) begin
      total++;
      if (bad[b]) $display("FAIL timing_bit%0d got wrong level want %b for 4 cycles", b, p[b]); else passed++;
    end
    n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    total++; if (done !== 1'b1) $display("FAIL timing_done got %b want 1", done); else passed++;
    @(negedge clk);
  endtask

  task automatic test_beef;
    int n, bad;
    foreach (mem[i]) mem[i] = 16'h0;
    mem[5] = 16'hBEEF;
    rxq.delete();
    run_start(0, 1'b0, n);
    @(negedge clk);
    total++; if (rxq[11] !== 9'h1EF) $display("FAIL beef_lo got %h want 1ef", rxq[11]); else passed++;
    total++; if (rxq[12] !== 9'h1BE) $display("FAIL beef_hi got %h want 1be", rxq[12]); else passed++;
    total++; if (rxq[65] !== 9'h151) $display("FAIL beef_chk got %h want 151", rxq[65]); else passed++;
    bad = 0;
    for (int i = 1; i < 65; i++) if (i != 11 && i != 12 && rxq[i] !== 9'h100) bad++;
    total++; if (bad !== 0) $display("FAIL beef_rest got %0d bad bytes want 0", bad); else passed++;
  endtask

  task automatic test_ignored_start;
    int n;
    rxq.delete();
    // byte 10 is on the line around cycle 2+10*40
    run_start(402, 1'b1, n);
    total++; if (n !== 2642) $display("FAIL ign_latency got %0d want 2642", n); else passed++;
    repeat (100) @(negedge clk);
    total++; if (done_cnt !== 1) $display("FAIL ign_done_count got %0d want 1", done_cnt); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL ign_busy got %b want 0", busy); else passed++;
    total++; if (rxq.size() !== 66) $display("FAIL ign_len got %0d want 66", rxq.size()); else passed++;
  endtask

  task automatic test_reset_mid;
    int n;
    logic [7:0] x;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // byte 30 mid-bit
    repeat (2 + 30 * 40 + 17) @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL rmid_busy_before got %b want 1", busy); else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++; if (tx !== 1'b1) $display("FAIL rmid_tx got %b want 1", tx); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else passed++;
    rst = 1'b0;
    repeat (60) @(negedge clk);
    rxq.delete();
    foreach (mem[i]) mem[i] = pat(i);
    x = 8'h0;
    for (int a = 0; a < 32; a++) x = x ^ pat(a)[7:0] ^ pat(a)[15:8];
    run_start(0, 1'b0, n);
    @(negedge clk);
    total++; if (rxq.size() !== 66) $display("FAIL rmid_len got %0d want 66", rxq.size()); else passed++;
    total++; if (rxq[0] !== 9'h1A5) $display("FAIL rmid_header got %h want 1a5", rxq[0]); else passed++;
    total++; if (rxq[65] !== {1'b1, x}) $display("FAIL rmid_chk got %h want %h", rxq[65], {1'b1, x}); else passed++;
  endtask

  task automatic test_pattern;
    int n, bad;
    logic [7:0] x;
    foreach (mem[i]) mem[i] = pat(i);
    x = 8'h0;
    for (int a = 0; a < 32; a++) x = x ^ pat(a)[7:0] ^ pat(a)[15:8];
    rxq.delete();
    run_start(0, 1'b0, n);
    @(negedge clk);
    bad = 0;
    for (int a = 0; a < 32; a++)
      if ({rxq[2 + 2 * a], rxq[1 + 2 * a]} !== {1'b1, pat(a)[15:8], 1'b1, pat(a)[7:0]}) begin
        bad++;
        $display("FAIL pat_word%0d got %h%h want %h", a, rxq[2 + 2 * a][7:0], rxq[1 + 2 * a][7:0], pat(a));
      end
    total++; if (bad !== 0) $display("FAIL pat_words got %0d bad words want 0", bad); else passed++;
    total++; if (rxq[65] !== {1'b1, x}) $display("FAIL pat_chk got %h want %h", rxq[65], {1'b1, x}); else passed++;
    total++; if (done_cnt !== 1) $display("FAIL pat_done_count got %0d want 1", done_cnt); else passed++;
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 16'h0;
    test_reset();
    test_zero_ram();
    test_bit_timing();
    test_beef();
    test_ignored_start();
    test_reset_mid();
    test_pattern();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
